rs_mem: RTL and testbench

In-order reservation station for load/store micro-ops, sitting between dispatch/rename and `fu_mem`. Holds up to DEPTH memory ops in program order, tracks source-operand readiness via CDB wakeup, and issues the oldest op to `fu_mem` once its operands are ready and `fu_mem_ready` is high. It also squashes mispredicted-path entries by ROB age.

---
 rtl/types_pkg.sv | 26 ++
 rtl/rs_mem_age_cmp.sv | 11 +
 rtl/rs_mem.sv | 125 ++++++++++++
 tb/tb_rs_mem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the memory reservation station: op payload, opcode constants and ROB age helper.
package types_pkg;
  localparam int RS_MEM_DEPTH = 8;
  localparam int NUM_CDB      = 3;
  localparam int TAG_W        = 7;
  localparam int ROB_W        = 5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0]       Opcode;
    logic [TAG_W-1:0] ps1;
    logic [TAG_W-1:0] ps2;
    logic [TAG_W-1:0] pd;
    logic [31:0]      imm;
    logic [ROB_W-1:0] rob_index;
  } rs_data;

  // Distance from the ROB head, modulo the 16-entry ROB.
  function automatic logic [3:0] rob_age(input logic [ROB_W-1:0] tag, input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] d;
    d = tag - head;
    return d[3:0];
  endfunction
endpackage

// File: rtl/rs_mem_age_cmp.sv
// Combinational "entry is younger than the mispredicting branch" comparator.
module rob_age_cmp
  import types_pkg::*;
(
  input  logic [ROB_W-1:0] tag,
  input  logic [ROB_W-1:0] branch_tag,
  input  logic [ROB_W-1:0] head,
  output logic             younger
);
  assign younger = rob_age(tag, head) > rob_age(branch_tag, head);
endmodule

// File: rtl/rs_mem.sv
// In-order load/store reservation station with CDB wakeup and ROB-age flush.
// Define RS_MEM_WAKEUP_BYPASS_EN to let the head issue in the same cycle as its wakeup.
module rs_mem
  import types_pkg::*;
#(
  parameter int DEPTH      = RS_MEM_DEPTH,
  parameter int NUM_WAKEUP = NUM_CDB
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                disp_valid,
  input  rs_data                              disp_data,
  input  logic                                disp_ps1_ready,
  input  logic                                disp_ps2_ready,
  output logic                                disp_ready,
  input  logic [NUM_WAKEUP-1:0]               wakeup_valid,
  input  logic [NUM_WAKEUP-1:0][TAG_W-1:0]    wakeup_tag,
  input  logic                                fu_mem_ready,
  output logic                                issued,
  output rs_data                              data_out,
  input  logic [ROB_W-1:0]                    rob_head,
  input  logic                                mispredict,
  input  logic [ROB_W-1:0]                    mispredict_tag,
  output logic [$clog2(DEPTH+1)-1:0]          occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  rs_data           payload [DEPTH];
  logic [DEPTH-1:0] valid, rdy1, rdy2, younger;
  logic [PW-1:0]    head, tail, idx, flush_tail;
  logic [CW-1:0]    count, flush_count;
  logic             flush_hit, h_rdy1, h_rdy2, issuable, do_disp;

  // Tag 0 is the hardwired-ready register; otherwise look for a live CDB match.
  function automatic logic wake_hit(input logic [TAG_W-1:0] tag);
    logic h;
    h = (tag == '0);
    for (int k = 0; k < NUM_WAKEUP; k++)
      if (wakeup_valid[k] && wakeup_tag[k] == tag) h = 1'b1;
    return h;
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    rob_age_cmp u_cmp (
      .tag        (payload[g].rob_index),
      .branch_tag (mispredict_tag),
      .head       (rob_head),
      .younger    (younger[g])
    );
  end

`ifdef RS_MEM_WAKEUP_BYPASS_EN
  assign h_rdy1 = rdy1[head] | wake_hit(payload[head].ps1);
  assign h_rdy2 = rdy2[head] | wake_hit(payload[head].ps2);
`else
  assign h_rdy1 = rdy1[head];
  assign h_rdy2 = rdy2[head];
`endif

  assign issuable   = valid[head] && h_rdy1 && (h_rdy2 || payload[head].Opcode == OP_LOAD);
  assign issued     = issuable && fu_mem_ready && !mispredict;
  assign data_out   = valid[head] ? payload[head] : rs_data'('0);
  assign disp_ready = (count != CW'(DEPTH));
  assign do_disp    = disp_valid && disp_ready && !mispredict;
  assign occupancy  = count;

  // Walk from head in program order: the first squashed slot becomes the new tail.
  always_comb begin
    flush_hit   = 1'b0;
    flush_tail  = tail;
    flush_count = '0;
    idx         = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && younger[idx]) begin
        if (!flush_hit) flush_tail = idx;
        flush_hit = 1'b1;
      end else if (valid[idx]) begin
        flush_count = flush_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && wake_hit(payload[i].ps1)) rdy1[i] <= 1'b1;
        if (valid[i] && wake_hit(payload[i].ps2)) rdy2[i] <= 1'b1;
      end
      if (mispredict) begin
        for (int i = 0; i < DEPTH; i++)
          if (valid[i] && younger[i]) valid[i] <= 1'b0;
        if (flush_hit) tail <= flush_tail;
        count <= flush_count;
      end else begin
        if (issued) begin
          valid[head] <= 1'b0;
          head        <= head + 1'b1;
        end
        if (do_disp) begin
          valid[tail] <= 1'b1;
          rdy1[tail]  <= disp_ps1_ready | wake_hit(disp_data.ps1);
          rdy2[tail]  <= disp_ps2_ready | wake_hit(disp_data.ps2);
          tail        <= tail + 1'b1;
        end
        case ({do_disp, issued})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk)
    if (do_disp) payload[tail] <= disp_data;
endmodule

// File: tb/tb_rs_mem.sv
// Scoreboard bench for rs_mem: expected payloads queued on dispatch, checked in order on issue.
module tb_rs_mem;
  import types_pkg::*;
  localparam int NW = 3;

  logic clk = 0, reset = 1, disp_valid = 0, disp_ps1_ready = 0, disp_ps2_ready = 0;
  logic fu_mem_ready = 1, mispredict = 0;
  rs_data disp_data = '0, data_out;
  logic disp_ready, issued;
  logic [NW-1:0] wakeup_valid = '0;
  logic [NW-1:0][6:0] wakeup_tag = '0;
  logic [4:0] rob_head = '0, mispredict_tag = '0;
  logic [3:0] occupancy;

  int n_cmp = 0, n_fail = 0;
  rs_data exp_q[$];

  rs_mem dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_ps1_ready(disp_ps1_ready), .disp_ps2_ready(disp_ps2_ready), .disp_ready(disp_ready),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag), .fu_mem_ready(fu_mem_ready),
    .issued(issued), .data_out(data_out), .rob_head(rob_head), .mispredict(mispredict),
    .mispredict_tag(mispredict_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Issue monitor: every issue must match the oldest outstanding expected op.
  always @(negedge clk) begin
    if (!reset && issued) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_order got rob=%0d required no issue", data_out.rob_index);
      end else begin
        rs_data e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL issue_order got rob=%0d pd=%0d required rob=%0d pd=%0d",
                   data_out.rob_index, data_out.pd, e.rob_index, e.pd);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic rs_data mk(input logic [6:0] op, input logic [6:0] p1, input logic [6:0] p2,
                                input logic [4:0] rob);
    rs_data d;
    d.Opcode = op; d.ps1 = p1; d.ps2 = p2; d.pd = 7'(rob) + 7'd40;
    d.imm = $urandom; d.rob_index = rob;
    return d;
  endfunction

  task automatic dispatch(input logic [6:0] op, input logic [6:0] p1, input logic [6:0] p2,
                          input logic r1, input logic r2, input logic [4:0] rob);
    rs_data d;
    d = mk(op, p1, p2, rob);
    disp_valid = 1; disp_data = d; disp_ps1_ready = r1; disp_ps2_ready = r2;
    exp_q.push_back(d);
    cyc();
    disp_valid = 0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (occupancy != 0 && k < max) begin cyc(); k++; end
    n_cmp++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL drain occupancy=%0d required 0", occupancy); end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d required 0", occupancy); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got %b required 1", disp_ready); end
    n_cmp++; if (issued !== 1'b0) begin n_fail++; $display("FAIL reset_issued got %b required 0", issued); end
    n_cmp++; if (data_out !== rs_data'('0)) begin n_fail++; $display("FAIL reset_data got %h required 0", data_out); end
    cyc();
    reset = 0;
  endtask

  task automatic test_dispatch_issue();
    fu_mem_ready = 1;
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd3);
    @(negedge clk);
    n_cmp++; if (issued !== 1'b1) begin n_fail++; $display("FAIL di_issued got %b required 1", issued); end
    n_cmp++; if (data_out.rob_index !== 5'd3) begin n_fail++; $display("FAIL di_rob got %0d required 3", data_out.rob_index); end
    cyc();
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL di_occ got %0d required 0", occupancy); end
    n_cmp++; if (issued !== 1'b0) begin n_fail++; $display("FAIL di_idle got %b required 0", issued); end
    cyc();
  endtask

  task automatic test_wakeup_block();
    logic exp_c;
    logic [4:0] exp_rob;
`ifdef RS_MEM_WAKEUP_BYPASS_EN
    exp_c = 1'b1; exp_rob = 5'd5;
`else
    exp_c = 1'b0; exp_rob = 5'd4;
`endif
    fu_mem_ready = 1;
    dispatch(OP_STORE, 7'd5, 7'd12, 1, 0, 5'd4);
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd5);
    @(negedge clk);
    n_cmp++; if (issued !== 1'b0) begin n_fail++; $display("FAIL wk_blocked got %b required 0", issued); end
    n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL wk_occ got %0d required 2", occupancy); end
    cyc();
    wakeup_valid = 3'b010; wakeup_tag[1] = 7'd12;
    @(negedge clk);
    n_cmp++; if (issued !== exp_c) begin n_fail++; $display("FAIL wk_cycle_c got %b required %b", issued, exp_c); end
    cyc();
    wakeup_valid = '0; wakeup_tag[1] = '0;
    @(negedge clk);
    n_cmp++; if (issued !== 1'b1) begin n_fail++; $display("FAIL wk_cycle_c1 got %b required 1", issued); end
    n_cmp++; if (data_out.rob_index !== exp_rob) begin n_fail++; $display("FAIL wk_rob got %0d required %0d", data_out.rob_index, exp_rob); end
    cyc();
    drain(10);
  endtask

  task automatic test_full_wrap();
    fu_mem_ready = 0;
    for (int i = 0; i < 8; i++) dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'(i));
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_occ got %0d required 8", occupancy); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_disp_ready got %b required 0", disp_ready); end
    cyc();
    // Pop and attempted push in the same cycle: the push must be refused.
    fu_mem_ready = 1;
    disp_valid = 1; disp_data = mk(OP_LOAD, 7'd0, 7'd0, 5'd31); disp_ps1_ready = 1; disp_ps2_ready = 1;
    @(negedge clk);
    n_cmp++; if (issued !== 1'b1) begin n_fail++; $display("FAIL full_pop got %b required 1", issued); end
    cyc();
    disp_valid = 0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL full_after_pop got %0d required 7", occupancy); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed got %b required 1", disp_ready); end
    cyc();
    for (int i = 8; i < 16; i++) dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'(i));
    drain(40);
  endtask

  task automatic test_flush();
    fu_mem_ready = 0; rob_head = 5'd14;
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd14);
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd15);
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd0);
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd1);
    mispredict = 1; mispredict_tag = 5'd15; fu_mem_ready = 1;
    disp_valid = 1; disp_data = mk(OP_LOAD, 7'd0, 7'd0, 5'd2);
    @(negedge clk);
    n_cmp++; if (issued !== 1'b0) begin n_fail++; $display("FAIL fl_issue_suppr got %b required 0", issued); end
    cyc();
    mispredict = 0; disp_valid = 0;
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL fl_occ got %0d required 2", occupancy); end
    n_cmp++; if (data_out.rob_index !== 5'd14) begin n_fail++; $display("FAIL fl_head got %0d required 14", data_out.rob_index); end
    cyc();
    drain(10);
    // Flush that empties the buffer; the next dispatch must land at head.
    fu_mem_ready = 0; rob_head = 5'd0;
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd3);
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd4);
    mispredict = 1; mispredict_tag = 5'd2;
    cyc();
    mispredict = 0;
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL fl_empty got %0d required 0", occupancy); end
    cyc();
    fu_mem_ready = 1;
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd6);
    @(negedge clk);
    n_cmp++; if (data_out.rob_index !== 5'd6 || issued !== 1'b1)
      begin n_fail++; $display("FAIL fl_refill got rob=%0d issued=%b required rob=6 issued=1", data_out.rob_index, issued); end
    cyc();
    drain(5);
  endtask

  task automatic test_backpressure();
    fu_mem_ready = 0;
    dispatch(OP_STORE, 7'd0, 7'd0, 1, 1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (issued !== 1'b0 || occupancy !== 4'd1)
        begin n_fail++; $display("FAIL bp_hold got issued=%b occ=%0d required 0/1", issued, occupancy); end
      cyc();
    end
    fu_mem_ready = 1;
    @(negedge clk);
    n_cmp++; if (issued !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b required 1", issued); end
    cyc();
    drain(3);
  endtask

  task automatic test_reset_mid();
    fu_mem_ready = 0;
    for (int i = 0; i < 5; i++) dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'(20 + i));
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL rm_pre got %0d required 5", occupancy); end
    #2 reset = 1;
    #1;
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL rm_occ got %0d required 0", occupancy); end
    n_cmp++; if (issued !== 1'b0) begin n_fail++; $display("FAIL rm_issued got %b required 0", issued); end
    n_cmp++; if (data_out !== rs_data'('0)) begin n_fail++; $display("FAIL rm_data got %h required 0", data_out); end
    exp_q.delete();
    cyc(); cyc();
    reset = 0; fu_mem_ready = 1;
    dispatch(OP_LOAD, 7'd0, 7'd0, 1, 1, 5'd7);
    drain(5);
  endtask

  initial begin
    test_reset();
    test_dispatch_issue();
    test_wakeup_block();
    test_full_wrap();
    test_flush();
    test_backpressure();
    test_reset_mid();
    repeat (2) cyc();
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
